servo_sweep_ctrl: RTL and testbench

Multi-channel servo PWM driver with a start/busy/done handshake.
- Generates one fixed-period PWM frame stream per channel.
- On request, sweeps the selected channels from home (PULSE_MIN) to the far end (PULSE_MAX), holds there, sweeps back, holds, then reports done.
- Pulse width is slew-limited per frame, so servos never jump.
- Sits between the coin-handling control FSM and the servo output pins; supersedes the fixed single-channel, fixed-ramp shooter driver.

---
 rtl/servo_sweep_ctrl.sv | 140 ++++++++++++++
 tb/tb_servo_sweep_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/servo_sweep_ctrl.sv
// Multi-channel servo PWM driver: sweeps masked channels PULSE_MIN->PULSE_MAX->PULSE_MIN with per-frame slew limit.
// PWM/at_max/frame_tick are registered (1 clk latency); start is ignored while a sweep is in progress (no queuing).
module servo_sweep_ctrl #(
   parameter int NUM_CH      = 2,
   parameter int CNT_W       = 21,
   parameter int FRAME_CLKS  = 1000000,
   parameter int PULSE_MIN   = 50000,
   parameter int PULSE_MAX   = 100000,
   parameter int STEP        = 5000,
   parameter int HOLD_FRAMES = 31
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [NUM_CH-1:0] ch_sel,
   output logic              busy,
   output logic              done,
   output logic [NUM_CH-1:0] pwm,
   output logic              frame_tick,
   output logic [NUM_CH-1:0] at_max
);

   typedef enum logic [1:0] {IDLE, OUT, BACK, DONE} state_t;

   localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
   localparam logic [CNT_W-1:0] P_MIN  = CNT_W'(PULSE_MIN);
   localparam logic [CNT_W-1:0] P_MAX  = CNT_W'(PULSE_MAX);
   localparam logic [CNT_W-1:0] P_STEP = CNT_W'(STEP);
   localparam logic [CNT_W-1:0] F_LAST = CNT_W'(FRAME_CLKS - 1);
   localparam logic [CNT_W:0]   MIN_X  = (CNT_W+1)'(PULSE_MIN);
   localparam logic [CNT_W:0]   MAX_X  = (CNT_W+1)'(PULSE_MAX);
   localparam logic [CNT_W:0]   STEP_X = (CNT_W+1)'(STEP);
   localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_FRAMES - 1);

   state_t            state;
   logic [CNT_W-1:0]  frame_cnt;
   logic              frame_end;
   logic [CNT_W-1:0]  width [NUM_CH];
   logic [CNT_W-1:0]  up_w  [NUM_CH];
   logic [CNT_W-1:0]  dn_w  [NUM_CH];
   logic [NUM_CH-1:0] mask;
   logic [HW-1:0]     hold_cnt;
   logic              all_max;
   logic              all_min;

   assign frame_end = (frame_cnt == F_LAST);

   // Slew computations run one bit wider so width+STEP clamps instead of wrapping.
   always_comb begin
      all_max = 1'b1;
      all_min = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
         up_w[i] = (({1'b0, width[i]} + STEP_X) >= MAX_X) ? P_MAX : width[i] + P_STEP;
         dn_w[i] = ({1'b0, width[i]} <= (MIN_X + STEP_X)) ? P_MIN : width[i] - P_STEP;
         if (mask[i] && (width[i] != P_MAX)) all_max = 1'b0;
         if (mask[i] && (width[i] != P_MIN)) all_min = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt  <= '0;
         frame_tick <= 1'b0;
         pwm        <= '0;
         at_max     <= '0;
      end else begin
         frame_cnt  <= frame_end ? '0 : frame_cnt + 1'b1;
         frame_tick <= frame_end;
         for (int i = 0; i < NUM_CH; i++) begin
            pwm[i]    <= (frame_cnt < width[i]);
            at_max[i] <= (width[i] == P_MAX);
         end
      end
   end

   // busy/done are updated on the DONE->IDLE edge, so a held start re-triggers with a single busy-low cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         mask     <= '0;
         hold_cnt <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) width[i] <= P_MIN;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start && (ch_sel != '0)) begin
                  mask     <= ch_sel;
                  hold_cnt <= '0;
                  busy     <= 1'b1;
                  state    <= OUT;
                  if (frame_end) begin
                     for (int i = 0; i < NUM_CH; i++)
                        if (ch_sel[i]) width[i] <= up_w[i];
                  end
               end
            end
            OUT: begin
               if (frame_end) begin
                  if (all_max) begin
                     if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                        state    <= BACK;
                     end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                     end
                  end else begin
                     for (int i = 0; i < NUM_CH; i++)
                        if (mask[i]) width[i] <= up_w[i];
                  end
               end
            end
            BACK: begin
               if (frame_end) begin
                  if (all_min) begin
                     if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                        state    <= DONE;
                     end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                     end
                  end else begin
                     for (int i = 0; i < NUM_CH; i++)
                        if (mask[i]) width[i] <= dn_w[i];
                  end
               end
            end
            DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_servo_sweep_ctrl.sv
// Scoreboard bench: stimulus queues per-frame expectations, a negedge monitor measures each frame and compares.
module tb_servo_sweep_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [1:0] ch_sel;
   logic       busy;
   logic       done;
   logic [1:0] pwm;
   logic       frame_tick;
   logic [1:0] at_max;

   typedef struct {
      int frame;
      int w0;
      int w1;
      int busy;
      int done;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   frame_no = 0;
   int   samp = 0, hi0 = 0, hi1 = 0, bcnt = 0, dcnt = 0;
   int   sweep_w [9];

   servo_sweep_ctrl #(
      .NUM_CH(2), .CNT_W(21), .FRAME_CLKS(100), .PULSE_MIN(10),
      .PULSE_MAX(20), .STEP(4), .HOLD_FRAMES(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .ch_sel(ch_sel),
      .busy(busy), .done(done), .pwm(pwm), .frame_tick(frame_tick), .at_max(at_max)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s frame=%0d actual=%0d expected=%0d", name, frame_no, act, exp);
      end
   endtask

   // Monitor: a frame window closes on the sample where frame_tick is high.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         chk("reset_outputs", int'({pwm, at_max, busy, done, frame_tick}), 0);
         frame_no = 0;
         samp = 0; hi0 = 0; hi1 = 0; bcnt = 0; dcnt = 0;
      end else begin
         samp++;
         hi0  += int'(pwm[0]);
         hi1  += int'(pwm[1]);
         bcnt += int'(busy);
         dcnt += int'(done);
         if (frame_tick) begin
            frame_no++;
            if (frame_no > 1) chk("frame_len", samp, 100);
            while (exp_q.size() > 0 && exp_q[0].frame < frame_no) begin
               e = exp_q.pop_front();
               chk("missed_frame", frame_no, e.frame);
            end
            if (exp_q.size() > 0 && exp_q[0].frame == frame_no) begin
               e = exp_q.pop_front();
               chk("pwm0_width", hi0, e.w0);
               chk("pwm1_width", hi1, e.w1);
               chk("busy_cycles", bcnt, e.busy);
               chk("done_pulses", dcnt, e.done);
               chk("at_max0", int'(at_max[0]), int'(e.w0 == 20));
               chk("at_max1", int'(at_max[1]), int'(e.w1 == 20));
            end
            samp = 0; hi0 = 0; hi1 = 0; bcnt = 0; dcnt = 0;
         end
      end
   end

   task automatic push_frame(input int f, input int w0, input int w1, input int b, input int d);
      exp_t e;
      e.frame = f; e.w0 = w0; e.w1 = w1; e.busy = b; e.done = d;
      exp_q.push_back(e);
   endtask

   task automatic push_idle(input int f, input int b, input int d);
      push_frame(f, 10, 10, b, d);
   endtask

   // Sweep accepted during window k+1 (not on a frame end): frames k+1..k+10.
   task automatic push_sweep(input int k, input logic [1:0] m, input int busy_first, input int done_first);
      for (int j = 1; j <= 10; j++) begin
         int w;
         w = (j == 1) ? 10 : sweep_w[j-2];
         push_frame(k + j, m[0] ? w : 10, m[1] ? w : 10,
                    (j == 1) ? busy_first : 100, (j == 1) ? done_first : 0);
      end
   endtask

   task automatic wait_tick();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_tick && n < 300);
      #1;
      if (!frame_tick) chk("tick_timeout", 0, 1);
   endtask

   task automatic wait_frame(input int target);
      int g;
      g = 0;
      while (frame_no < target && g < 40) begin
         wait_tick();
         g++;
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() > 0) chk("drain_timeout", exp_q.size(), 0);
   endtask

   task automatic pulse_start(input logic [1:0] m);
      ch_sel = m;
      start  = 1'b1;
      @(negedge clk);
      #1;
      start  = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog frame=%0d", frame_no);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k;
      sweep_w = '{14, 18, 20, 20, 20, 16, 12, 10, 10};
      rst_n  = 1'b1;
      start  = 1'b0;
      ch_sel = 2'b00;
      #2 rst_n = 1'b0;

      // Idle after reset: holding pulses only.
      for (int f = 1; f <= 3; f++) push_idle(f, 0, 0);
      repeat (3) @(negedge clk);
      @(posedge clk); #2 rst_n = 1'b1;
      wait_drain();

      // Single sweep on ch0.
      wait_tick();
      k = frame_no;
      push_sweep(k, 2'b01, 100, 0);
      push_idle(k + 11, 0, 1);
      push_idle(k + 12, 0, 0);
      pulse_start(2'b01);
      wait_drain();

      // Starts during OUT and during DONE are ignored.
      wait_tick();
      k = frame_no;
      push_sweep(k, 2'b01, 100, 0);
      push_idle(k + 11, 0, 1);
      push_idle(k + 12, 0, 0);
      pulse_start(2'b01);
      wait_frame(k + 3);
      pulse_start(2'b11);
      wait_frame(k + 10);
      pulse_start(2'b01);
      wait_drain();

      // Empty channel mask is not a request.
      wait_tick();
      k = frame_no;
      for (int j = 1; j <= 3; j++) push_idle(k + j, 0, 0);
      pulse_start(2'b00);
      wait_drain();

      // Reset in the middle of the return sweep.
      wait_tick();
      k = frame_no;
      push_sweep(k, 2'b11, 100, 0);
      pulse_start(2'b11);
      wait_frame(k + 6);
      repeat (30) @(negedge clk);
      exp_q.delete();
      @(posedge clk); #1 rst_n = 1'b0;
      for (int f = 1; f <= 3; f++) push_idle(f, 0, 0);
      repeat (3) @(negedge clk);
      @(posedge clk); #2 rst_n = 1'b1;
      wait_drain();

      // Held start: back-to-back sweeps on both channels.
      wait_tick();
      k = frame_no;
      push_sweep(k, 2'b11, 100, 0);
      push_sweep(k + 10, 2'b11, 99, 1);
      push_idle(k + 21, 0, 1);
      push_idle(k + 22, 0, 0);
      ch_sel = 2'b11;
      start  = 1'b1;
      wait_frame(k + 12);
      start  = 1'b0;
      wait_drain();

      chk("queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
